// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared SHA-3 padder constants and state encoding
package sha3_pkg;

  localparam int R_BLOCK_SIZE = 1152;
  localparam int RATE_BYTES = R_BLOCK_SIZE / 8;
  localparam logic [7:0] DOMAIN_SHA3 = 8'h06;
  localparam logic [7:0] DOMAIN_KECCAK = 8'h01;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EXTRA,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/sha3_pad_byte.sv
// rtl/sha3_pad_byte.sv - pad byte for one block position given the pad start
module sha3_pad_byte #(
  parameter int RATE_BYTES = sha3_pkg::RATE_BYTES,
  parameter logic [7:0] DOMAIN = sha3_pkg::DOMAIN_SHA3,
  parameter int CW = $clog2(RATE_BYTES)
) (
  input  logic [CW-1:0] position_i,
  input  logic [CW-1:0] cnt_i,
  input  logic          last_i,
  output logic [7:0]    pad_o
);

  // Domain byte at the pad start, 0x80 terminator in the top byte; both may coincide.
  always_comb begin
    pad_o = 8'h00;
    if (last_i) begin
      if (position_i == cnt_i) pad_o = DOMAIN;
      if (position_i == CW'(RATE_BYTES - 1)) pad_o = pad_o | 8'h80;
    end
  end

endmodule

// File: rtl/sha3_block_padder.sv
// rtl/sha3_block_padder.sv - byte-serial SHA-3/Keccak message padder emitting rate blocks
module sha3_block_padder #(
  parameter int R_BLOCK_SIZE = sha3_pkg::R_BLOCK_SIZE,
  parameter logic [7:0] DOMAIN = sha3_pkg::DOMAIN_SHA3
) (
  input  logic                  CLK,
  input  logic                  A_RST,
  input  logic [7:0]            DIN,
  input  logic                  DIN_VALID,
  input  logic                  DIN_LAST,
  input  logic                  DIN_NOBYTE,
  output logic                  DIN_READY,
  output logic [0:R_BLOCK_SIZE-1] BLK_OUT,
  output logic                  BLK_VALID,
  output logic                  BLK_LAST,
  input  logic                  BLK_READY
);
  import sha3_pkg::*;

  localparam int RATE_B = R_BLOCK_SIZE / 8;
  localparam int CW = $clog2(RATE_B);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic pend_q, pend_d;
  logic [7:0] blk_q [RATE_B];
  logic [7:0] blk_d [RATE_B];
  logic [7:0] pad_w [RATE_B];
  logic [CW-1:0] pad_start;
  logic pad_en, wr_en, clr;
  logic at_top;

  assign at_top = (cnt_q == CW'(RATE_B - 1));

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    pend_d = pend_q;
    pad_en = 1'b0;
    pad_start = cnt_q;
    wr_en = 1'b0;
    clr = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (DIN_VALID && DIN_LAST) begin
          wr_en = !DIN_NOBYTE;
          pad_start = DIN_NOBYTE ? cnt_q : cnt_q + CW'(1);
          cnt_d = '0;
          state_d = ST_HOLD;
          // A last byte filling the top slot leaves no room for padding.
          if (!DIN_NOBYTE && at_top) begin
            pend_d = 1'b1;
            last_d = 1'b0;
          end else begin
            pad_en = 1'b1;
            last_d = 1'b1;
          end
        end else if (DIN_VALID && !DIN_NOBYTE) begin
          wr_en = 1'b1;
          if (at_top) begin
            cnt_d = '0;
            last_d = 1'b0;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_EXTRA: begin
        pad_start = '0;
        pad_en = 1'b1;
        last_d = 1'b1;
        pend_d = 1'b0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (BLK_READY) begin
          clr = 1'b1;
          last_d = 1'b0;
          state_d = pend_q ? ST_EXTRA : ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Buffer is kept zero above CNT, so data and padding can simply be OR-ed in.
  always_comb begin
    for (int i = 0; i < RATE_B; i++) begin
      blk_d[i] = clr ? 8'h00 : blk_q[i];
      if (wr_en && cnt_q == CW'(i)) blk_d[i] = DIN;
      blk_d[i] = blk_d[i] | pad_w[i];
    end
  end

  for (genvar i = 0; i < RATE_B; i++) begin : g_byte
    sha3_pad_byte #(
      .RATE_BYTES(RATE_B),
      .DOMAIN(DOMAIN)
    ) u_pad (
      .position_i(CW'(i)),
      .cnt_i(pad_start),
      .last_i(pad_en),
      .pad_o(pad_w[i])
    );
    assign BLK_OUT[8*i +: 8] = blk_q[i];
  end

  always_ff @(posedge CLK or posedge A_RST) begin
    if (A_RST) begin
      state_q <= ST_FILL;
      cnt_q <= '0;
      last_q <= 1'b0;
      pend_q <= 1'b0;
      for (int i = 0; i < RATE_B; i++) blk_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      pend_q <= pend_d;
      for (int i = 0; i < RATE_B; i++) blk_q[i] <= blk_d[i];
    end
  end

  assign DIN_READY = (state_q == ST_FILL);
  assign BLK_VALID = (state_q == ST_HOLD);
  assign BLK_LAST = last_q;

endmodule

// File: tb/tb_sha3_block_padder.sv
// tb/tb_sha3_block_padder.sv - self-checking bench for sha3_block_padder (SHA-3 and Keccak domains)
module tb_sha3_block_padder;

  localparam int RB = 144;
  localparam int RBITS = RB * 8;
  localparam int MSG_LIMIT = 5000;

  typedef logic [0:RBITS-1] blk_t;
  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       nobyte;
  } beat_t;

  logic CLK = 1'b0;
  logic A_RST;
  logic [7:0] DIN;
  logic DIN_VALID, DIN_LAST, DIN_NOBYTE, BLK_READY;
  logic s_ready, k_ready, s_valid, k_valid, s_last, k_last;
  blk_t s_out, k_out;

  int errors = 0;
  int checks = 0;
  blk_t exp_s[$];
  blk_t exp_k[$];
  logic exp_l[$];
  blk_t seen_s, seen_k;
  logic [7:0] m[$];

  always #5 CLK = ~CLK;

  sha3_block_padder #(.R_BLOCK_SIZE(RBITS), .DOMAIN(8'h06)) u_sha3 (
    .CLK(CLK), .A_RST(A_RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_LAST(DIN_LAST),
    .DIN_NOBYTE(DIN_NOBYTE), .DIN_READY(s_ready), .BLK_OUT(s_out), .BLK_VALID(s_valid),
    .BLK_LAST(s_last), .BLK_READY(BLK_READY)
  );

  sha3_block_padder #(.R_BLOCK_SIZE(RBITS), .DOMAIN(8'h01)) u_keccak (
    .CLK(CLK), .A_RST(A_RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_LAST(DIN_LAST),
    .DIN_NOBYTE(DIN_NOBYTE), .DIN_READY(k_ready), .BLK_OUT(k_out), .BLK_VALID(k_valid),
    .BLK_LAST(k_last), .BLK_READY(BLK_READY)
  );

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkblk(input string tag, input blk_t obs, input blk_t exp);
    int first;
    first = 0;
    checks++;
    assert (obs === exp) else begin
      errors++;
      for (int j = RB - 1; j >= 0; j--) if (obs[8*j +: 8] !== exp[8*j +: 8]) first = j;
      $error("FAIL %s byte %0d observed=%h expected=%h", tag, first, obs[8*first +: 8], exp[8*first +: 8]);
    end
  endtask

  // Reference: message || domain || zeros, top byte OR 0x80, cut into rate blocks.
  task automatic add_expect(input logic [7:0] msg[$]);
    logic [7:0] ps[$];
    logic [7:0] pk[$];
    int nblk;
    ps = msg;
    pk = msg;
    ps.push_back(8'h06);
    pk.push_back(8'h01);
    while (ps.size() % RB != 0) begin
      ps.push_back(8'h00);
      pk.push_back(8'h00);
    end
    ps[ps.size()-1] = ps[ps.size()-1] | 8'h80;
    pk[pk.size()-1] = pk[pk.size()-1] | 8'h80;
    nblk = ps.size() / RB;
    for (int b = 0; b < nblk; b++) begin
      blk_t vs, vk;
      for (int j = 0; j < RB; j++) begin
        vs[8*j +: 8] = ps[b*RB + j];
        vk[8*j +: 8] = pk[b*RB + j];
      end
      exp_s.push_back(vs);
      exp_k.push_back(vk);
      exp_l.push_back(b == nblk - 1);
    end
  endtask

  task automatic run_msg(input logic [7:0] msg[$], input bit empty_tail, input int stall,
                         input int gap_pct, input int junk_pct);
    beat_t bq[$];
    beat_t b;
    int real_left, data_acc, cyc, stall_cnt;
    bit exp_vnext, hs_pend, hs_ready;
    real_left = msg.size() + (empty_tail ? 1 : 0);
    data_acc = 0; cyc = 0; stall_cnt = 0;
    exp_vnext = 0; hs_pend = 0; hs_ready = 0;
    add_expect(msg);
    for (int i = 0; i < msg.size(); i++) begin
      if ($urandom_range(0, 99) < junk_pct) bq.push_back('{d: 8'($urandom), last: 1'b0, nobyte: 1'b1});
      bq.push_back('{d: msg[i], last: (i == msg.size() - 1) && !empty_tail, nobyte: 1'b0});
    end
    if (empty_tail) bq.push_back('{d: 8'($urandom), last: 1'b1, nobyte: 1'b1});
    while ((bq.size() > 0 || exp_s.size() > 0) && cyc < MSG_LIMIT) begin
      @(negedge CLK);
      cyc++;
      if (exp_vnext) chk1("blk_latency", s_valid, 1);
      if (hs_pend) chk1("ready_after_hs", s_ready, hs_ready);
      exp_vnext = 0;
      hs_pend = 0;
      BLK_READY = 0;
      if (s_valid) begin
        chk1("block_expected", exp_s.size() > 0, 1);
        if (exp_s.size() > 0) begin
          chkblk("blk_sha3", s_out, exp_s[0]);
          chkblk("blk_keccak", k_out, exp_k[0]);
          chk1("blk_last_sha3", s_last, exp_l[0]);
          chk1("blk_last_keccak", k_last, exp_l[0]);
          chk1("ready_in_hold", s_ready, 0);
          if (stall_cnt >= stall) begin
            BLK_READY = 1;
            seen_s = s_out;
            seen_k = k_out;
            void'(exp_s.pop_front());
            void'(exp_k.pop_front());
            void'(exp_l.pop_front());
            stall_cnt = 0;
            hs_pend = 1;
            hs_ready = !(exp_s.size() > 0 && real_left == 0);
          end else begin
            stall_cnt++;
          end
        end
      end
      DIN_VALID = 0; DIN_LAST = 0; DIN_NOBYTE = 0;
      if (bq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        b = bq[0];
        DIN_VALID = 1; DIN = b.d; DIN_LAST = b.last; DIN_NOBYTE = b.nobyte;
        if (s_ready) begin
          void'(bq.pop_front());
          if (!b.nobyte) data_acc++;
          if (b.last || !b.nobyte) real_left--;
          exp_vnext = b.last || (!b.nobyte && data_acc % RB == 0);
        end
      end
    end
    @(negedge CLK);
    if (hs_pend) chk1("ready_after_hs", s_ready, hs_ready);
    BLK_READY = 0;
    DIN_VALID = 0;
    chk1("msg_done_in_time", cyc < MSG_LIMIT, 1);
    chk1("no_stray_block", s_valid, 0);
  endtask

  initial begin
    A_RST = 1; DIN = 0; DIN_VALID = 0; DIN_LAST = 0; DIN_NOBYTE = 0; BLK_READY = 0;
    repeat (2) @(negedge CLK);
    chk1("rst_valid", s_valid, 0);
    chk1("rst_last", s_last, 0);
    chkblk("rst_buf", s_out, '0);
    A_RST = 0;
    @(negedge CLK);
    chk1("ready_after_rst", s_ready, 1);

    m = {};
    m.push_back(8'h53); m.push_back(8'h58); m.push_back(8'h7B); m.push_back(8'h99);
    run_msg(m, 0, 0, 0, 0);
    chk1("keccak_head", seen_k[0:31], 32'h53587B99);
    chk1("keccak_domain", seen_k[32:39], 8'h01);
    chk1("keccak_tail", seen_k[RBITS-8 +: 8], 8'h80);

    m = {};
    run_msg(m, 1, 0, 0, 0);
    chk1("empty_first", seen_s[0:7], 8'h06);
    chk1("empty_top", seen_s[RBITS-8 +: 8], 8'h80);

    m = {};
    for (int i = 0; i < 143; i++) m.push_back(8'hAA);
    run_msg(m, 0, 0, 0, 0);
    chk1("pad_143", seen_s[RBITS-8 +: 8], 8'h86);

    m = {};
    for (int i = 0; i < 144; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 0, 0, 0);

    m = {};
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 10, 0, 0);

    m = {};
    for (int i = 0; i < 144; i++) m.push_back(8'($urandom));
    run_msg(m, 1, 2, 20, 10);

    m = {};
    for (int i = 0; i < 143; i++) m.push_back(8'($urandom));
    run_msg(m, 1, 0, 0, 0);

    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      DIN_VALID = 1; DIN = 8'($urandom); DIN_LAST = 0; DIN_NOBYTE = 0;
    end
    @(negedge CLK);
    DIN_VALID = 0;
    #2 A_RST = 1;
    @(negedge CLK);
    chk1("midmsg_rst_valid", s_valid, 0);
    chkblk("midmsg_rst_buf", s_out, '0);
    A_RST = 0;
    @(negedge CLK);
    chk1("midmsg_rst_ready", s_ready, 1);
    repeat (3) @(negedge CLK);
    chk1("midmsg_no_block", s_valid, 0);
    m = {};
    for (int i = 0; i < 4; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 0, 0, 0);

    for (int i = 0; i < 144; i++) begin
      @(negedge CLK);
      DIN_VALID = 1; DIN = 8'($urandom); DIN_LAST = 0; DIN_NOBYTE = 0;
    end
    @(negedge CLK);
    DIN_VALID = 0;
    chk1("hold_before_rst", s_valid, 1);
    #2 A_RST = 1;
    @(negedge CLK);
    chk1("hold_rst_valid", s_valid, 0);
    chkblk("hold_rst_buf", s_out, '0);
    A_RST = 0;
    @(negedge CLK);
    chk1("hold_rst_ready", s_ready, 1);

    for (int n = 0; n < 8; n++) begin
      int len;
      bit tail;
      len = $urandom_range(0, 300);
      tail = (len == 0) || ($urandom_range(0, 1) == 1);
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      run_msg(m, tail, $urandom_range(0, 3), 25, 10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha3_block_padder.md
SHA3_BLOCK_PADDER -- requirements
Module: sha3_block_padder

Interface
REQ-001 The block SHALL have parameter R_BLOCK_SIZE, default 1152, giving the rate block width in bits (a multiple of 8); RATE_BYTES = R_BLOCK_SIZE/8.
REQ-002 The block SHALL have parameter DOMAIN, default 8'h06, giving the domain-separation/first pad byte.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port A_RST, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port DIN, input, 8 bits: message byte.
REQ-006 The block SHALL have port DIN_VALID, input, 1 bit: DIN/DIN_LAST/DIN_NOBYTE are valid.
REQ-007 The block SHALL have port DIN_LAST, input, 1 bit: the beat ends the message.
REQ-008 The block SHALL have port DIN_NOBYTE, input, 1 bit: with DIN_LAST, the beat carries no data byte (empty tail or empty message).
REQ-009 The block SHALL have port DIN_READY, output, 1 bit: a byte is accepted when DIN_VALID and DIN_READY are both 1 on a clock edge.
REQ-010 The block SHALL have port BLK_OUT, output, [0:R_BLOCK_SIZE-1]: padded rate block; byte i occupies bits [8i:8i+7], MSB of the byte at bit 8i.
REQ-011 The block SHALL have port BLK_VALID, output, 1 bit: BLK_OUT is valid.
REQ-012 The block SHALL have port BLK_LAST, output, 1 bit: BLK_OUT is the final block of the message.
REQ-013 The block SHALL have port BLK_READY, input, 1 bit: the consumer takes the block when BLK_VALID and BLK_READY are both 1.

Function
REQ-014 The block SHALL implement states FILL, EXTRA and HOLD.
REQ-015 In FILL, DIN_READY SHALL be 1; each accepted data byte is written to byte position CNT, and CNT increments (range 0..RATE_BYTES-1).
REQ-016 An accepted non-last byte at CNT = RATE_BYTES-1 SHALL move the block to HOLD with BLK_LAST=0 and CNT=0.
REQ-017 A last beat at final data position p < RATE_BYTES-1 SHALL write DOMAIN at byte p+1, zeros above it, and OR 8'h80 into byte RATE_BYTES-1 (p+1 = RATE_BYTES-1 gives DOMAIN|8'h80); the block goes to HOLD with BLK_LAST=1.
REQ-018 A last data byte at position RATE_BYTES-1 SHALL give HOLD with BLK_LAST=0, then EXTRA.
REQ-019 EXTRA SHALL build the block DOMAIN, zeros, 8'h80 (last byte) and go to HOLD with BLK_LAST=1; DIN_READY SHALL be 0 in EXTRA.
REQ-020 DIN_NOBYTE=1 with DIN_LAST=1 SHALL pad starting at byte CNT; at CNT=0 this gives the same block as EXTRA.
REQ-021 DIN_NOBYTE without DIN_LAST SHALL be ignored (no byte written).
REQ-022 BLK_VALID SHALL rise the cycle after the completing beat is accepted (one-cycle latency).
REQ-023 In HOLD, DIN_READY SHALL be 0, and BLK_OUT/BLK_LAST SHALL stay stable until the block is taken.
REQ-024 On handshake, the block SHALL go to EXTRA if pending, else to FILL with the buffer cleared to zero.
REQ-025 Unpadded bytes SHALL always be zero; bytes accepted after a last beat start a new message.

Reset
REQ-026 A_RST=1 SHALL asynchronously force FILL, CNT=0, buffer all zeros, BLK_VALID=0, BLK_LAST=0, and the extra-pending flag=0.
REQ-027 DIN_READY SHALL read 1 one cycle after A_RST deasserts.
REQ-028 A reset mid-message or in HOLD SHALL discard all partial and held data with no block emitted.

Structure
REQ-029 The shared package sha3_pkg SHALL hold R_BLOCK_SIZE, RATE_BYTES, the DOMAIN defaults (8'h06 SHA3, 8'h01 Keccak) and the state enumeration.
REQ-030 The pad-byte computation SHALL be a sub-module, sha3_pad_byte (inputs: position, CNT, last; output: pad byte).

Verification
REQ-031 DOMAIN=8'h01, bytes 53 58 7B 99 with last on 99 -> one block 53587B9901, 1104 zero bits, 80; BLK_LAST=1.
REQ-032 DOMAIN=8'h06, a single empty beat (DIN_NOBYTE=1, DIN_LAST=1) -> block 06, zeros, 80; BLK_LAST=1.
REQ-033 A 143-byte message of 8'hAA -> byte 143 = 8'h86, with a single block.
REQ-034 A 144-byte message -> a data block with BLK_LAST=0, then block 06..80 with BLK_LAST=1; DIN_READY=0 throughout.
REQ-035 BLK_READY held 0 for 10 cycles -> BLK_OUT stable and DIN_READY=0; on release, the next byte is accepted the cycle after the handshake.
REQ-036 A_RST pulsed after 50 bytes -> no block emitted; a following 4-byte message yields a clean padded block.
